// File: rtl/demux_16bit_4way_buf.sv
// Registered 1-to-4 demultiplexer for 16-bit words, one-entry holding register per channel.
// Optional per-channel delivery counters on the stats port when DEMUX_STATS_EN is defined.
module demux_16bit_4way_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_in,
  input  logic        i_s0,
  input  logic        i_s1,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  output logic [15:0] o_out1,
  output logic [15:0] o_out2,
  output logic [15:0] o_out3,
  output logic [15:0] o_out4,
  output logic        o_out_valid1,
  output logic        o_out_valid2,
  output logic        o_out_valid3,
  output logic        o_out_valid4,
  input  logic        i_out_ready1,
  input  logic        i_out_ready2,
  input  logic        i_out_ready3,
  input  logic        i_out_ready4,
  output logic        o_idle
`ifdef DEMUX_STATS_EN
  ,
  output logic [31:0] o_stats
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_t;

  ch_state_t   r_state [4];
  logic [15:0] r_data  [4];
  logic [1:0]  w_sel;
  logic [3:0]  w_valid;
  logic [3:0]  w_out_ready;
  logic [3:0]  w_accept;
  logic [3:0]  w_deliver;

  assign w_sel       = {i_s1, i_s0};
  assign w_out_ready = {i_out_ready4, i_out_ready3, i_out_ready2, i_out_ready1};
  assign w_deliver   = w_valid & w_out_ready;

  // A full channel can still take a word in the cycle its consumer drains it.
  assign o_in_ready = (~w_valid[w_sel]) | w_out_ready[w_sel];
  assign o_idle     = ~(|w_valid);

  // Decode channel state and the one-hot accept strobe.
  always_comb begin
    w_accept = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      w_valid[c] = (r_state[c] == FULL);
    end
    if (i_in_valid && o_in_ready) begin
      w_accept[w_sel] = 1'b1;
    end else begin
      w_accept = 4'b0000;
    end
  end

  // Per-channel EMPTY/FULL state machine with its data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        r_state[c] <= EMPTY;
        r_data[c]  <= 16'h0000;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        case (r_state[c])
          EMPTY: begin
            if (w_accept[c]) begin
              r_state[c] <= FULL;
              r_data[c]  <= i_in;
            end
          end
          FULL: begin
            if (w_accept[c]) begin
              r_data[c] <= i_in;
            end else if (w_deliver[c]) begin
              r_state[c] <= EMPTY;
            end
          end
          default: r_state[c] <= EMPTY;
        endcase
      end
    end
  end

  assign o_out1       = r_data[0];
  assign o_out2       = r_data[1];
  assign o_out3       = r_data[2];
  assign o_out4       = r_data[3];
  assign o_out_valid1 = w_valid[0];
  assign o_out_valid2 = w_valid[1];
  assign o_out_valid3 = w_valid[2];
  assign o_out_valid4 = w_valid[3];

`ifdef DEMUX_STATS_EN
  logic [7:0] r_cnt [4];

  // Wrapping delivery counters, one per channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        r_cnt[c] <= 8'h00;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (w_deliver[c]) begin
          r_cnt[c] <= r_cnt[c] + 8'h01;
        end
      end
    end
  end

  assign o_stats = {r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]};
`endif

endmodule

// File: tb/tb_demux_16bit_4way_buf.sv
// Self-checking bench for demux_16bit_4way_buf: queue-based channel model plus directed literal checks.
module tb_demux_16bit_4way_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] t_in = 16'h0000;
  logic [1:0]  t_sel = 2'b00;
  logic        t_valid = 1'b0;
  logic [3:0]  t_ordy = 4'b0000;

  logic        d_in_ready, d_idle;
  logic [15:0] d_out [4];
  logic        d_ov1, d_ov2, d_ov3, d_ov4;
  logic [3:0]  d_valid;
  logic [31:0] d_stats;

  int n_pass = 0;
  int n_total = 0;

  logic [15:0] q      [4][$];
  logic [15:0] dlog   [4][$];
  logic [15:0] m_last [4];
  logic [7:0]  m_cnt  [4];

  always #5 clk = ~clk;

  demux_16bit_4way_buf dut (
    .clk(clk), .rst(rst),
    .i_in(t_in), .i_s0(t_sel[0]), .i_s1(t_sel[1]), .i_in_valid(t_valid),
    .o_in_ready(d_in_ready),
    .o_out1(d_out[0]), .o_out2(d_out[1]), .o_out3(d_out[2]), .o_out4(d_out[3]),
    .o_out_valid1(d_ov1), .o_out_valid2(d_ov2), .o_out_valid3(d_ov3), .o_out_valid4(d_ov4),
    .i_out_ready1(t_ordy[0]), .i_out_ready2(t_ordy[1]),
    .i_out_ready3(t_ordy[2]), .i_out_ready4(t_ordy[3]),
    .o_idle(d_idle)
`ifdef DEMUX_STATS_EN
    , .o_stats(d_stats)
`endif
  );

`ifndef DEMUX_STATS_EN
  assign d_stats = 32'h0000_0000;
`endif
  assign d_valid = {d_ov4, d_ov3, d_ov2, d_ov1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  function automatic logic model_ready(input logic [1:0] sel);
    return (q[sel].size() == 0) || t_ordy[sel];
  endfunction

  // Model: each channel is a FIFO of depth one; deliveries pop, accepts push.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        q[c].delete();
        dlog[c].delete();
        m_last[c] = 16'h0000;
        m_cnt[c]  = 8'h00;
      end
    end else begin
      logic rdy;
      rdy = model_ready(t_sel);
      for (int c = 0; c < 4; c++) begin
        if (q[c].size() != 0 && t_ordy[c]) begin
          dlog[c].push_back(q[c].pop_front());
          m_cnt[c] = m_cnt[c] + 8'h01;
        end
      end
      if (t_valid && rdy) begin
        q[t_sel].push_back(t_in);
        m_last[t_sel] = t_in;
      end
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    check("in_ready", {31'd0, d_in_ready}, {31'd0, model_ready(t_sel)});
    check("idle", {31'd0, d_idle},
          {31'd0, (q[0].size() + q[1].size() + q[2].size() + q[3].size()) == 0});
    for (int c = 0; c < 4; c++) begin
      check($sformatf("out_valid%0d", c + 1), {31'd0, d_valid[c]}, {31'd0, q[c].size() != 0});
      check($sformatf("out%0d", c + 1), {16'd0, d_out[c]}, {16'd0, m_last[c]});
    end
`ifdef DEMUX_STATS_EN
    check("stats", d_stats, {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]});
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] w, input logic [1:0] s, input logic v);
    t_in = w; t_sel = s; t_valid = v;
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_idle", {31'd0, d_idle}, 32'd1);
    check("rst_in_ready", {31'd0, d_in_ready}, 32'd1);
    check("rst_valids", {28'd0, d_valid}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Routing, consumers stalled
    drive(16'hFFFF, 2'b00, 1'b1); step();
    check("route_out1", {16'd0, d_out[0]}, 32'h0000_FFFF);
    check("route_valids1", {28'd0, d_valid}, 32'h1);
    drive(16'hFFFE, 2'b01, 1'b1); step();
    check("route_out2", {16'd0, d_out[1]}, 32'h0000_FFFE);
    drive(16'h7FFF, 2'b10, 1'b1); step();
    check("route_out3", {16'd0, d_out[2]}, 32'h0000_7FFF);
    drive(16'hFFFD, 2'b11, 1'b1); step();
    check("route_out4", {16'd0, d_out[3]}, 32'h0000_FFFD);
    check("route_out1_kept", {16'd0, d_out[0]}, 32'h0000_FFFF);
    check("route_valids_all", {28'd0, d_valid}, 32'hF);
    check("model_pin_out1", {16'd0, m_last[0]}, 32'h0000_FFFF);
    drive(16'h0000, 2'b00, 1'b0);

    // Backpressure: drain ch2 first, then stall on ch1 and retarget to ch2
    t_ordy = 4'b0010; step(); t_ordy = 4'b0000;
    check("drain_ch2", {28'd0, d_valid}, 32'hD);
    drive(16'h1111, 2'b00, 1'b1);
    check("bp_in_ready_ch1", {31'd0, d_in_ready}, 32'd0);
    drive(16'h2222, 2'b01, 1'b1);
    check("bp_in_ready_ch2", {31'd0, d_in_ready}, 32'd1);
    step();
    drive(16'h0000, 2'b00, 1'b0);
    check("bp_out1_held", {16'd0, d_out[0]}, 32'h0000_FFFF);
    check("bp_out2", {16'd0, d_out[1]}, 32'h0000_2222);

    // Simultaneous accept and delivery on ch3
    t_ordy = 4'b0100; step(); t_ordy = 4'b0000;
    drive(16'h1234, 2'b10, 1'b1); step();
    t_ordy = 4'b0100;
    drive(16'h5678, 2'b10, 1'b1);
    check("sim_out3_before", {16'd0, d_out[2]}, 32'h0000_1234);
    check("sim_in_ready", {31'd0, d_in_ready}, 32'd1);
    step();
    drive(16'h0000, 2'b00, 1'b0);
    check("sim_out3_after", {16'd0, d_out[2]}, 32'h0000_5678);
    check("sim_valid3", {31'd0, d_ov3}, 32'd1);
    check("sim_delivered", {16'd0, dlog[2][dlog[2].size() - 1]}, 32'h0000_1234);
    step();
    t_ordy = 4'b0000;
    check("sim_drained", {31'd0, d_ov3}, 32'd0);
    check("sim_out3_kept", {16'd0, d_out[2]}, 32'h0000_5678);

    // Streaming 8 words into ch4
    t_ordy = 4'b1000; step();
    dlog[3].delete();
    for (int i = 0; i < 8; i++) begin
      drive(16'hA0A0 + 16'(i), 2'b11, 1'b1);
      check("stream_in_ready", {31'd0, d_in_ready}, 32'd1);
      step();
    end
    drive(16'h0000, 2'b00, 1'b0); step();
    t_ordy = 4'b0000;
    check("stream_count", dlog[3].size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("stream_order", {16'd0, dlog[3][i]}, 32'h0000_A0A0 + i);
    end

    // Asynchronous reset mid-stream with ch2 full
    drive(16'hBEEF, 2'b01, 1'b1); step();
    drive(16'h0000, 2'b00, 1'b0);
    check("mid_ch2_full", {31'd0, d_ov2}, 32'd1);
    rst = 1'b1; #1;
    check("mid_rst_valids", {28'd0, d_valid}, 32'd0);
    check("mid_rst_out2", {16'd0, d_out[1]}, 32'd0);
    check("mid_rst_out1", {16'd0, d_out[0]}, 32'd0);
    check("mid_rst_idle", {31'd0, d_idle}, 32'd1);
    check("mid_rst_in_ready", {31'd0, d_in_ready}, 32'd1);
    step(); rst = 1'b0;

    // 257 deliveries on ch2
    t_ordy = 4'b0010;
    for (int i = 0; i < 257; i++) begin
      drive(16'(i), 2'b01, 1'b1);
      step();
    end
    drive(16'h0000, 2'b00, 1'b0); step();
    t_ordy = 4'b0000;
    check("stats_log_count", dlog[1].size(), 32'd257);
    check("stats_log_last", {16'd0, dlog[1][256]}, 32'd256);
`ifdef DEMUX_STATS_EN
    check("stats_cnt2", d_stats, 32'h0000_0100);
`endif
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
